// File: rtl/ram_bytelane_sync.sv
// Byte-addressed big-endian data RAM with request/finished handshake, wait states and signed loads.
// Optional RAM_ALIGN_ABORT_EN adds an abort output that rejects misaligned halfword/word accesses.
module ram_bytelane_sync #(
    parameter int ADDR_W      = 9,
    parameter int DEPTH       = 512,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              rw,
    input  logic [ADDR_W-1:0] adr,
    input  logic [31:0]       data,
    input  logic [1:0]        dataSize,
    input  logic              sgn,
    output logic [31:0]       out,
    output logic              finished,
    output logic              busy
`ifdef RAM_ALIGN_ABORT_EN
    ,
    output logic              abort
`endif
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] DONE    = 2'd2;
    localparam logic [3:0] WAIT_LAST = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    logic [7:0]        mem [DEPTH];
    logic [1:0]        state;
    logic [3:0]        cnt;
    logic              rw_q;
    logic              sgn_q;
    logic [ADDR_W-1:0] adr_q;
    logic [31:0]       data_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] adr_p1, adr_p2, adr_p3;
    logic [31:0]       rd_raw;
    logic              misaligned;
    logic              commit;

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] size,
                                           input logic s);
        logic signed [7:0]  sb;
        logic signed [15:0] sh;
        sb = raw[7:0];
        sh = raw[15:0];
        case (size)
            2'b00:   extend = s ? 32'(sb) : {24'd0, raw[7:0]};
            2'b01:   extend = s ? 32'(sh) : {16'd0, raw[15:0]};
            default: extend = raw;
        endcase
    endfunction

`ifdef RAM_ALIGN_ABORT_EN
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
        case (size)
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = lo[0];
            default: is_misaligned = (lo != 2'b00);
        endcase
    endfunction

    assign misaligned = is_misaligned(size_q, adr_q[1:0]);
`else
    assign misaligned = 1'b0;
`endif

    // Byte addresses wrap naturally because DEPTH == 2**ADDR_W.
    assign adr_p1 = adr_q + ADDR_W'(1);
    assign adr_p2 = adr_q + ADDR_W'(2);
    assign adr_p3 = adr_q + ADDR_W'(3);

    always_comb begin
        rd_raw = 32'd0;
        case (size_q)
            2'b00:   rd_raw = {24'd0, mem[adr_q]};
            2'b01:   rd_raw = {16'd0, mem[adr_q], mem[adr_p1]};
            default: rd_raw = {mem[adr_q], mem[adr_p1], mem[adr_p2], mem[adr_p3]};
        endcase
    end

    assign commit = (state == DONE) && reset_n && !misaligned && !rw_q;

    always_ff @(posedge clk) begin
        if (commit) begin
            case (size_q)
                2'b00: mem[adr_q] <= data_q[7:0];
                2'b01: begin
                    mem[adr_q]  <= data_q[15:8];
                    mem[adr_p1] <= data_q[7:0];
                end
                default: begin
                    mem[adr_q]  <= data_q[31:24];
                    mem[adr_p1] <= data_q[23:16];
                    mem[adr_p2] <= data_q[15:8];
                    mem[adr_p3] <= data_q[7:0];
                end
            endcase
        end
    end

    // Request fields are captured only on acceptance and held for the whole transaction.
    always_ff @(posedge clk) begin
        if (state == IDLE && en) begin
            rw_q   <= rw;
            adr_q  <= adr;
            data_q <= data;
            size_q <= dataSize;
            sgn_q  <= sgn;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            out      <= 32'd0;
            finished <= 1'b0;
            busy     <= 1'b0;
`ifdef RAM_ALIGN_ABORT_EN
            abort    <= 1'b0;
`endif
        end else begin
            finished <= 1'b0;
`ifdef RAM_ALIGN_ABORT_EN
            abort    <= 1'b0;
`endif
            if (finished) begin
                busy <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (en) begin
                        state <= (WAIT_STATES > 0) ? ST_WAIT : DONE;
                        cnt   <= 4'd0;
                        busy  <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (cnt == WAIT_LAST) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    finished <= 1'b1;
                    if (rw_q && !misaligned) begin
                        out <= extend(rd_raw, size_q, sgn_q);
                    end
`ifdef RAM_ALIGN_ABORT_EN
                    abort <= misaligned;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_bytelane_sync.sv
// Randomised and directed bench for ram_bytelane_sync: two instances (1 and 3 wait states)
// checked every cycle against a transaction-level byte-array model.
module tb_ram_bytelane_sync;

    localparam int DEPTH = 512;
    localparam int WS0   = 1;
    localparam int WS1   = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n  [2];
    logic        en_v   [2];
    logic        rw_v   [2];
    logic        sgn_v  [2];
    logic [8:0]  adr_v  [2];
    logic [31:0] data_v [2];
    logic [1:0]  size_v [2];
    logic [31:0] out_v  [2];
    logic        fin_v  [2];
    logic        busy_v [2];
    logic        abort_v[2];

    logic [31:0] exp_out  [2];
    logic        exp_fin  [2];
    logic        exp_busy [2];
    logic        exp_abort[2];
    logic [7:0]  mdl [2][DEPTH];

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    ram_bytelane_sync #(.ADDR_W(9), .DEPTH(DEPTH), .WAIT_STATES(WS0)) u0 (
        .clk(clk), .reset_n(rst_n[0]), .en(en_v[0]), .rw(rw_v[0]), .adr(adr_v[0]),
        .data(data_v[0]), .dataSize(size_v[0]), .sgn(sgn_v[0]), .out(out_v[0]),
        .finished(fin_v[0]), .busy(busy_v[0])
`ifdef RAM_ALIGN_ABORT_EN
        , .abort(abort_v[0])
`endif
    );

    ram_bytelane_sync #(.ADDR_W(9), .DEPTH(DEPTH), .WAIT_STATES(WS1)) u1 (
        .clk(clk), .reset_n(rst_n[1]), .en(en_v[1]), .rw(rw_v[1]), .adr(adr_v[1]),
        .data(data_v[1]), .dataSize(size_v[1]), .sgn(sgn_v[1]), .out(out_v[1]),
        .finished(fin_v[1]), .busy(busy_v[1])
`ifdef RAM_ALIGN_ABORT_EN
        , .abort(abort_v[1])
`endif
    );

`ifndef RAM_ALIGN_ABORT_EN
    initial begin
        abort_v[0] = 1'b0;
        abort_v[1] = 1'b0;
    end
`endif

    task automatic cmp(input string nm, input int k, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s[dut%0d] t=%0t got %h expected %h", nm, k, $time, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                cmp("out", k, out_v[k], exp_out[k]);
                cmp("finished", k, {31'd0, fin_v[k]}, {31'd0, exp_fin[k]});
                cmp("busy", k, {31'd0, busy_v[k]}, {31'd0, exp_busy[k]});
                cmp("abort", k, {31'd0, abort_v[k]}, {31'd0, exp_abort[k]});
            end
        end
    end

    function automatic int ws(input int k);
        return (k == 0) ? WS0 : WS1;
    endfunction

    function automatic bit misal(input logic [1:0] sz, input int a);
`ifdef RAM_ALIGN_ABORT_EN
        if (sz == 2'b00) return 1'b0;
        if (sz == 2'b01) return (a % 2) != 0;
        return (a % 4) != 0;
`else
        return 1'b0;
`endif
    endfunction

    // One full transaction; expectations change just after the edges where outputs must change.
    task automatic op(input int k, input bit r, input int a, input logic [31:0] d,
                      input logic [1:0] sz, input bit s);
        int n;
        longint v;
        @(negedge clk);
        en_v[k] = 1'b1; rw_v[k] = r; adr_v[k] = 9'(a); data_v[k] = d;
        size_v[k] = sz; sgn_v[k] = s;
        @(posedge clk); #1;
        en_v[k] = 1'b0; rw_v[k] = 1'($urandom); adr_v[k] = 9'($urandom);
        data_v[k] = $urandom; size_v[k] = 2'($urandom); sgn_v[k] = 1'($urandom);
        exp_busy[k] = 1'b1;
        repeat (ws(k)) @(posedge clk);
        @(posedge clk); #1;
        n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        if (misal(sz, a)) begin
            exp_abort[k] = 1'b1;
        end else if (!r) begin
            for (int i = 0; i < n; i++) mdl[k][(a + i) % DEPTH] = d[8*(n-1-i) +: 8];
        end else begin
            v = 0;
            for (int i = 0; i < n; i++) v = v * 256 + longint'(mdl[k][(a + i) % DEPTH]);
            if (s && n < 4 && v >= (longint'(1) << (8*n - 1))) v = v - (longint'(1) << (8*n));
            exp_out[k] = v[31:0];
        end
        exp_fin[k] = 1'b1;
        @(posedge clk); #1;
        exp_fin[k] = 1'b0;
        exp_busy[k] = 1'b0;
        exp_abort[k] = 1'b0;
    endtask

    task automatic lit(input int k, input string nm, input logic [31:0] want);
        cmp(nm, k, out_v[k], want);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0; en_v[k] = 1'b0; rw_v[k] = 1'b0; adr_v[k] = 9'd0;
            data_v[k] = 32'd0; size_v[k] = 2'b00; sgn_v[k] = 1'b0;
            exp_out[k] = 32'd0; exp_fin[k] = 1'b0; exp_busy[k] = 1'b0; exp_abort[k] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        for (int k = 0; k < 2; k++)
            for (int w = 0; w < DEPTH / 4; w++) op(k, 1'b0, w * 4, $urandom, 2'b10, 1'b0);

        op(0, 0, 16, 32'hDEADBEEF, 2'b10, 0);
        op(0, 1, 16, 32'h0, 2'b10, 0);  lit(0, "word16", 32'hDEADBEEF);
        op(0, 1, 16, 32'h0, 2'b00, 0);  lit(0, "byte16", 32'h000000DE);
        op(0, 1, 17, 32'h0, 2'b00, 0);  lit(0, "byte17", 32'h000000AD);
        op(0, 1, 18, 32'h0, 2'b00, 0);  lit(0, "byte18", 32'h000000BE);
        op(0, 1, 19, 32'h0, 2'b00, 0);  lit(0, "byte19", 32'h000000EF);

        op(0, 0, 32, 32'h00000000, 2'b10, 0);
        op(0, 0, 32, 32'hFFFFFF0F, 2'b00, 0);
        op(0, 0, 33, 32'h00000002, 2'b00, 0);
        op(0, 0, 34, 32'hAAAA0004, 2'b00, 0);
        op(0, 0, 35, 32'h00000008, 2'b00, 0);
        op(0, 1, 32, 32'h0, 2'b10, 0);  lit(0, "lanes32", 32'h0F020408);

        op(0, 0, 40, 32'h00000080, 2'b00, 0);
        op(0, 1, 40, 32'h0, 2'b00, 1);  lit(0, "sbyte", 32'hFFFFFF80);
        op(0, 1, 40, 32'h0, 2'b00, 0);  lit(0, "ubyte", 32'h00000080);
        op(0, 0, 42, 32'h00008001, 2'b01, 0);
        op(0, 1, 42, 32'h0, 2'b01, 1);  lit(0, "shalf", 32'hFFFF8001);
        op(0, 1, 42, 32'h0, 2'b10, 1);  lit(0, "wsgnign", {16'h8001, mdl[0][44], mdl[0][45]});

`ifndef RAM_ALIGN_ABORT_EN
        op(0, 0, 510, 32'h11223344, 2'b10, 0);
        op(0, 1, 510, 32'h0, 2'b00, 0); lit(0, "wrap510", 32'h00000011);
        op(0, 1, 511, 32'h0, 2'b00, 0); lit(0, "wrap511", 32'h00000022);
        op(0, 1, 0, 32'h0, 2'b00, 0);   lit(0, "wrap0", 32'h00000033);
        op(0, 1, 1, 32'h0, 2'b00, 0);   lit(0, "wrap1", 32'h00000044);
        op(0, 1, 510, 32'h0, 2'b10, 0); lit(0, "wrapword", 32'h11223344);
`else
        op(0, 0, 64, 32'hA1B2C3D4, 2'b10, 0);
        op(0, 0, 65, 32'h12345678, 2'b10, 0);
        op(0, 1, 64, 32'h0, 2'b10, 0);  lit(0, "abort_keep", 32'hA1B2C3D4);
        op(0, 0, 66, 32'h00005566, 2'b01, 0);
        op(0, 1, 64, 32'h0, 2'b10, 0);  lit(0, "half66", 32'hA1B25566);
`endif

        repeat (200) op(0, 1'($urandom), $urandom_range(0, DEPTH - 1), $urandom,
                        2'($urandom), 1'($urandom));
        repeat (60)  op(1, 1'($urandom), $urandom_range(0, DEPTH - 1), $urandom,
                        2'($urandom), 1'($urandom));

        // Abandon a write in the wait phase of the 3-wait-state instance.
        op(1, 0, 64, 32'h01020304, 2'b10, 0);
        op(1, 1, 64, 32'h0, 2'b10, 0);
        @(negedge clk);
        en_v[1] = 1'b1; rw_v[1] = 1'b0; adr_v[1] = 9'd64; data_v[1] = 32'hCAFEBABE;
        size_v[1] = 2'b10; sgn_v[1] = 1'b0;
        @(posedge clk); #1;
        en_v[1] = 1'b0;
        exp_busy[1] = 1'b1;
        @(negedge clk);
        rst_n[1] = 1'b0;
        @(posedge clk); #1;
        exp_busy[1] = 1'b0;
        exp_out[1] = 32'd0;
        lit(1, "rst_out", 32'd0);
        @(negedge clk);
        rst_n[1] = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        op(1, 1, 64, 32'h0, 2'b10, 0);  lit(1, "rst_keep", 32'h01020304);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram_bytelane_sync.md
Name: ram_bytelane_sync

Overview:
- Parametrised synchronous byte-addressed data memory for the ARM datapath; next generation of the 512x8 RAM.
- Supports byte, halfword and word access, big-endian.
- Adds a clocked request/finished handshake with a programmable wait-state count, and sign-extended loads for LDRSB/LDRSH.
- Sits between the memory-stage control unit and the load/store datapath.

Parameters:
- ADDR_W, 9, byte-address width.
- DEPTH, 512, number of bytes; must equal 2**ADDR_W.
- WAIT_STATES, 1, extra cycles between request acceptance and finished; range 0..15.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- en  in  1  request strobe; sampled only in IDLE.
- rw  in  1  1 = read, 0 = write.
- adr  in  ADDR_W  byte address of the most-significant byte accessed.
- data  in  32  write data, right-justified (byte in [7:0], halfword in [15:0]).
- dataSize  in  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as word).
- sgn  in  1  read only: 1 = sign-extend byte/halfword, 0 = zero-extend.
- out  out  32  read data, right-justified and extended.
- finished  out  1  one-cycle completion pulse.
- busy  out  1  high from the cycle after acceptance until finished falls.

Behaviour:
- Reset: reset_n sampled low at an edge forces state IDLE, out=0, finished=0, busy=0, wait counter=0. Memory array is not cleared. Reset mid-transaction abandons it; a pending write is not committed.
- States: IDLE, WAIT, DONE.
  - IDLE: en=1 at an edge latches rw, adr, data, dataSize and sgn, and sets busy=1. Goes to WAIT if WAIT_STATES>0, else to DONE.
  - WAIT: counter counts up to WAIT_STATES-1, then goes to DONE. Inputs are ignored.
  - DONE: write commits, or read updates out, at this edge; finished=1 for exactly this cycle; then returns to IDLE.
- Latency: finished is asserted WAIT_STATES+1 cycles after the accepting edge. Minimum request-to-request spacing is WAIT_STATES+2 cycles.
- en held high through DONE is re-sampled in the following IDLE cycle; the second request is accepted then, with no bubble-free chaining.
- Byte order is big-endian:
  - Word: mem[a] = data[31:24], mem[a+1] = [23:16], mem[a+2] = [15:8], mem[a+3] = [7:0].
  - Halfword: mem[a] = data[15:8], mem[a+1] = data[7:0].
  - Byte: mem[a] = data[7:0].
  - Reads assemble bytes in the same order.
- Address arithmetic is modulo DEPTH: a word at DEPTH-2 uses bytes DEPTH-2, DEPTH-1, 0, 1. Misaligned accesses are legal (see optional feature).
- Read extension:
  - Byte: sgn=1 replicates bit 7 into [31:8]; sgn=0 zero-fills.
  - Halfword: same rule using bit 15.
  - Word: sgn is ignored.
- out holds its value across writes and idle cycles; it changes only in DONE of a read (or on reset).
- A write only modifies the addressed bytes; all others are untouched.

Optional Feature:
- Macro RAM_ALIGN_ABORT_EN.
- Defined:
  - Adds output abort (1 bit, reset 0).
  - Halfword with adr[0]=1, or word/reserved size with adr[1:0]!=0, is misaligned.
  - A misaligned access still completes through WAIT/DONE with normal latency; finished and abort pulse together.
  - No bytes are written and out keeps its previous value.
- Undefined: no abort port; misaligned accesses proceed with modulo wrap as described above.

Test Plan:
- WAIT_STATES=1: reset, write word 32'hDEADBEEF at adr 16, then read word at 16 -> finished exactly 2 cycles after each accept; out=32'hDEADBEEF; byte reads at 16..19 return 32'hDE, 32'hAD, 32'hBE, 32'hEF.
- Byte-lane isolation: word 32'h00000000 at 32, byte writes 32'h0F, 02, 04, 08 at 32..35 -> word read returns 32'h0F020408.
- Sign extension: byte 32'h80 at 40; read byte sgn=1 -> 32'hFFFFFF80; sgn=0 -> 32'h00000080. Halfword 32'h8001 at 42, sgn=1 -> 32'hFFFF8001.
- Wrap: word 32'h11223344 at adr 510 -> bytes 510=11, 511=22, 0=33, 1=44; word read at 510 returns 32'h11223344.
- Reset mid-op with WAIT_STATES=3: write 32'hCAFEBABE at 64; drop reset_n during WAIT -> no finished; out=0; later read at 64 returns the prior contents.
- RAM_ALIGN_ABORT_EN: word write 32'h12345678 at adr 65 -> finished=1 and abort=1 in the same cycle; a subsequent read at 64 is unchanged; a halfword write at 66 completes with abort=0.
